// File: rtl/mem_port_arbiter.sv
// Shares one single-port data RAM between the core data port and a host port; fixed core priority with host starvation guard.
// Latency: grant and mem command registered one cycle after the request is sampled; read data returns one cycle after that.
// Backpressure: requesters hold req until gnt; MEM_ARB_RR_EN selects round-robin ties instead of the starvation guard.
module mem_port_arbiter #(
    parameter int AW       = 8,
    parameter int MAX_WAIT = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [3:0]    core_be,
    input  logic [7:0]    core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [31:0]   core_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [3:0]    host_be,
    input  logic [31:0]   host_wdata,
    input  logic          host_lock,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [31:0]   host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, CORE, HOST, HLOCK} state_t;

    localparam int LCW = $clog2(LOCK_MAX + 1);

    state_t         state;
    logic [LCW-1:0] lock_cnt;
    logic           lock_hold;
    logic           host_pri;
    logic           pick_core;
    logic           pick_host;

`ifdef MEM_ARB_RR_EN
    logic last_host;

    assign host_pri = !last_host;
`else
    logic [7:0] wait_cnt;

    assign host_pri = (wait_cnt == 8'(MAX_WAIT));
`endif

    // A held lock keeps the port; leaving HLOCK always favours a waiting core.
    always_comb begin
        pick_core = 1'b0;
        pick_host = 1'b0;
        lock_hold = (state == HLOCK) && host_req && host_lock && (lock_cnt != LCW'(LOCK_MAX));
        if (lock_hold) begin
            pick_host = 1'b1;
        end else if (core_req && ((state == HLOCK) || !host_pri || !host_req)) begin
            pick_core = 1'b1;
        end else if (host_req) begin
            pick_host = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            lock_cnt    <= '0;
            core_gnt    <= 1'b0;
            host_gnt    <= 1'b0;
            core_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
`ifdef MEM_ARB_RR_EN
            last_host   <= 1'b1;
`else
            wait_cnt    <= '0;
`endif
        end else begin
            core_gnt <= pick_core;
            host_gnt <= pick_host;
            mem_en   <= pick_core || pick_host;

            if (pick_core) begin
                mem_we    <= core_we;
                mem_addr  <= core_addr;
                mem_be    <= core_be;
                mem_wdata <= {4{core_wdata}};
            end else if (pick_host) begin
                mem_we    <= host_we;
                mem_addr  <= host_addr;
                mem_be    <= host_be;
                mem_wdata <= host_wdata;
            end else begin
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_be    <= '0;
                mem_wdata <= '0;
            end

            if (pick_host) begin
                state <= host_lock ? HLOCK : HOST;
            end else if (pick_core) begin
                state <= CORE;
            end else begin
                state <= IDLE;
            end

            // Counts consecutive locked host grants, restarting at 1 on a fresh lock.
            if (pick_host && host_lock) begin
                lock_cnt <= lock_hold ? lock_cnt + LCW'(1) : LCW'(1);
            end else begin
                lock_cnt <= '0;
            end

`ifdef MEM_ARB_RR_EN
            if (pick_host) begin
                last_host <= 1'b1;
            end else if (pick_core) begin
                last_host <= 1'b0;
            end
`else
            if (pick_host) begin
                wait_cnt <= '0;
            end else if (host_req && (wait_cnt != 8'(MAX_WAIT))) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
`endif

            core_rvalid <= core_gnt && !mem_we;
            host_rvalid <= host_gnt && !mem_we;
        end
    end

    assign core_rdata = core_rvalid ? mem_rdata : 32'h0;
    assign host_rdata = host_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector table plus hand sequences for contention, host lock, lock timeout and async reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we;
    logic [7:0]  core_addr;
    logic [3:0]  core_be;
    logic [7:0]  core_wdata;
    logic        core_gnt, core_rvalid;
    logic [31:0] core_rdata;
    logic        host_req, host_we, host_lock;
    logic [7:0]  host_addr;
    logic [3:0]  host_be;
    logic [31:0] host_wdata;
    logic        host_gnt, host_rvalid;
    logic [31:0] host_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.AW(8), .MAX_WAIT(8), .LOCK_MAX(16)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_be(core_be),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_be(host_be),
        .host_wdata(host_wdata), .host_lock(host_lock), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        creq, cwe;
        logic [7:0]  caddr;
        logic [3:0]  cbe;
        logic [7:0]  cwd;
        logic        hreq, hwe;
        logic [7:0]  haddr;
        logic [3:0]  hbe;
        logic [31:0] hwd;
        logic        hlock;
        logic [31:0] rdata;
        logic        e_cgnt, e_hgnt, e_en, e_we;
        logic [7:0]  e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic        e_crv;
        logic [31:0] e_crd;
        logic        e_hrv;
        logic [31:0] e_hrd;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        core_req = 1'b0; core_we = 1'b0; core_addr = 8'h00; core_be = 4'h0; core_wdata = 8'h00;
        host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_be = 4'h0; host_wdata = 32'h0;
        host_lock = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic exp_h;

        vecs[0]  = '{1'b0,1'b0,8'h00,4'h0,8'h00, 1'b0,1'b0,8'h00,4'h0,32'h0,1'b0, 32'hDEADBEEF,
                     1'b0,1'b0,1'b0,1'b0,8'h00,4'h0,32'h0, 1'b0,32'h0, 1'b0,32'h0};
        vecs[1]  = '{1'b1,1'b0,8'h10,4'h1,8'h00, 1'b0,1'b0,8'h00,4'h0,32'h0,1'b0, 32'h11111111,
                     1'b1,1'b0,1'b1,1'b0,8'h10,4'h1,32'h0, 1'b0,32'h0, 1'b0,32'h0};
        vecs[2]  = '{1'b0,1'b0,8'h00,4'h0,8'h00, 1'b0,1'b0,8'h00,4'h0,32'h0,1'b0, 32'hAABBCCDD,
                     1'b0,1'b0,1'b0,1'b0,8'h00,4'h0,32'h0, 1'b1,32'hAABBCCDD, 1'b0,32'h0};
        vecs[3]  = '{1'b1,1'b1,8'h24,4'h4,8'h5A, 1'b0,1'b0,8'h00,4'h0,32'h0,1'b0, 32'h0,
                     1'b1,1'b0,1'b1,1'b1,8'h24,4'h4,32'h5A5A5A5A, 1'b0,32'h0, 1'b0,32'h0};
        vecs[4]  = '{1'b0,1'b0,8'h00,4'h0,8'h00, 1'b0,1'b0,8'h00,4'h0,32'h0,1'b0, 32'h12345678,
                     1'b0,1'b0,1'b0,1'b0,8'h00,4'h0,32'h0, 1'b0,32'h0, 1'b0,32'h0};
        vecs[5]  = '{1'b0,1'b0,8'h00,4'h0,8'h00, 1'b1,1'b0,8'h40,4'hF,32'hCAFEF00D,1'b0, 32'h0,
                     1'b0,1'b1,1'b1,1'b0,8'h40,4'hF,32'h0, 1'b0,32'h0, 1'b0,32'h0};
        vecs[6]  = '{1'b1,1'b0,8'h08,4'h2,8'h00, 1'b0,1'b0,8'h00,4'h0,32'h0,1'b0, 32'h0BADF00D,
                     1'b1,1'b0,1'b1,1'b0,8'h08,4'h2,32'h0, 1'b0,32'h0, 1'b1,32'h0BADF00D};
        vecs[7]  = '{1'b0,1'b0,8'h00,4'h0,8'h00, 1'b1,1'b1,8'h44,4'h3,32'h01020304,1'b0, 32'h55AA55AA,
                     1'b0,1'b1,1'b1,1'b1,8'h44,4'h3,32'h01020304, 1'b1,32'h55AA55AA, 1'b0,32'h0};
        vecs[8]  = '{1'b1,1'b0,8'h0C,4'hF,8'h00, 1'b1,1'b0,8'h48,4'hF,32'h0,1'b0, 32'h0,
                     1'b1,1'b0,1'b1,1'b0,8'h0C,4'hF,32'h0, 1'b0,32'h0, 1'b0,32'h0};
        vecs[9]  = '{1'b0,1'b0,8'h00,4'h0,8'h00, 1'b0,1'b0,8'h00,4'h0,32'h0,1'b0, 32'h00000077,
                     1'b0,1'b0,1'b0,1'b0,8'h00,4'h0,32'h0, 1'b1,32'h00000077, 1'b0,32'h0};
        vecs[10] = '{1'b0,1'b0,8'h00,4'h0,8'h00, 1'b0,1'b0,8'h00,4'h0,32'h0,1'b0, 32'h00000099,
                     1'b0,1'b0,1'b0,1'b0,8'h00,4'h0,32'h0, 1'b0,32'h0, 1'b0,32'h0};

        reset = 1'b0;
        clear_inputs();
        mem_rdata = 32'hFFFFFFFF;
        #12;
        chk("reset core_gnt", {31'h0, core_gnt}, 32'h0);
        chk("reset host_gnt", {31'h0, host_gnt}, 32'h0);
        chk("reset mem_en", {31'h0, mem_en}, 32'h0);
        chk("reset core_rdata", core_rdata, 32'h0);
        chk("reset host_rdata", host_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            core_req = vecs[i].creq; core_we = vecs[i].cwe; core_addr = vecs[i].caddr;
            core_be = vecs[i].cbe; core_wdata = vecs[i].cwd;
            host_req = vecs[i].hreq; host_we = vecs[i].hwe; host_addr = vecs[i].haddr;
            host_be = vecs[i].hbe; host_wdata = vecs[i].hwd; host_lock = vecs[i].hlock;
            mem_rdata = vecs[i].rdata;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d core_gnt", i), {31'h0, core_gnt}, {31'h0, vecs[i].e_cgnt});
            chk($sformatf("v%0d host_gnt", i), {31'h0, host_gnt}, {31'h0, vecs[i].e_hgnt});
            chk($sformatf("v%0d mem_en", i), {31'h0, mem_en}, {31'h0, vecs[i].e_en});
            if (vecs[i].e_en) begin
                chk($sformatf("v%0d mem_we", i), {31'h0, mem_we}, {31'h0, vecs[i].e_we});
                chk($sformatf("v%0d mem_addr", i), {24'h0, mem_addr}, {24'h0, vecs[i].e_addr});
                chk($sformatf("v%0d mem_be", i), {28'h0, mem_be}, {28'h0, vecs[i].e_be});
                if (vecs[i].e_we)
                    chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wd);
            end
            chk($sformatf("v%0d core_rvalid", i), {31'h0, core_rvalid}, {31'h0, vecs[i].e_crv});
            chk($sformatf("v%0d core_rdata", i), core_rdata, vecs[i].e_crd);
            chk($sformatf("v%0d host_rvalid", i), {31'h0, host_rvalid}, {31'h0, vecs[i].e_hrv});
            chk($sformatf("v%0d host_rdata", i), host_rdata, vecs[i].e_hrd);
            @(negedge clk);
        end

        // Both requesters held continuously.
        do_reset();
        core_req = 1'b1; core_addr = 8'h04; core_be = 4'hF;
        host_req = 1'b1; host_addr = 8'h80; host_be = 4'hF;
        for (int i = 1; i <= 18; i++) begin
            @(posedge clk);
            #1;
`ifdef MEM_ARB_RR_EN
            exp_h = (i % 2 == 0);
`else
            exp_h = (i % 9 == 0);
`endif
            chk($sformatf("contend c%0d host_gnt", i), {31'h0, host_gnt}, {31'h0, exp_h});
            chk($sformatf("contend c%0d core_gnt", i), {31'h0, core_gnt}, {31'h0, !exp_h});
        end

        // Three locked host writes while the core waits.
        do_reset();
        host_req = 1'b1; host_lock = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_be = 4'hF;
        host_wdata = 32'h600DF00D;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("lock g%0d host_gnt", i), {31'h0, host_gnt}, 32'h1);
            chk($sformatf("lock g%0d core_gnt", i), {31'h0, core_gnt}, 32'h0);
            @(negedge clk);
            core_req = 1'b1;
            if (i == 3) begin
                host_req = 1'b0;
                host_lock = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("lock release core_gnt", {31'h0, core_gnt}, 32'h1);
        chk("lock release host_gnt", {31'h0, host_gnt}, 32'h0);

        // Stuck lock is broken after LOCK_MAX grants.
        do_reset();
        host_req = 1'b1; host_lock = 1'b1; host_we = 1'b1; host_addr = 8'h60; host_be = 4'hF;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("timeout c%0d host_gnt", i), {31'h0, host_gnt}, {31'h0, (i <= 16)});
            chk($sformatf("timeout c%0d core_gnt", i), {31'h0, core_gnt}, {31'h0, (i == 17)});
            if (i == 1) begin
                @(negedge clk);
                core_req = 1'b1;
            end
        end

        // Asynchronous reset while a host read is in flight.
        do_reset();
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h30; host_be = 4'hF;
        mem_rdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        chk("arst pre host_gnt", {31'h0, host_gnt}, 32'h1);
        host_req = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst host_gnt", {31'h0, host_gnt}, 32'h0);
        chk("arst mem_en", {31'h0, mem_en}, 32'h0);
        chk("arst mem_addr", {24'h0, mem_addr}, 32'h0);
        chk("arst host_rdata", host_rdata, 32'h0);
        @(posedge clk);
        #1;
        chk("arst held host_rvalid", {31'h0, host_rvalid}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("arst release host_rvalid", {31'h0, host_rvalid}, 32'h0);
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h14; core_be = 4'h1;
        @(posedge clk);
        #1;
        chk("arst first core_gnt", {31'h0, core_gnt}, 32'h1);
        chk("arst first mem_addr", {24'h0, mem_addr}, 32'h14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port 32-bit-wide data RAM between two requesters: the processor core's data port and a host port (program loader / debug master).
- Registered request/grant handshake, one memory command per cycle, fixed 1-cycle synchronous RAM read latency.
- Fixed priority (core first) with a starvation guard for the host, plus a host lock for atomic multi-beat sequences.
- Sits between the core's data-access bus and the data RAM instance.

Parameters:
- AW, 8, byte address width on all ports.
- MAX_WAIT, 8, host wait cycles before a forced host grant; range 1..255.
- LOCK_MAX, 16, maximum consecutive locked host grants before the lock is broken.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- core_req  input  1  core access request, held until core_gnt
- core_we  input  1  core write (1) / read (0)
- core_addr  input  AW  core byte address
- core_be  input  4  core byte lanes
- core_wdata  input  8  core write byte, replicated onto all four lanes
- core_gnt  output  1  core command issued this cycle
- core_rvalid  output  1  core read data valid
- core_rdata  output  32  core read word
- host_req  input  1  host request, held until host_gnt
- host_we  input  1  host write / read
- host_addr  input  AW  host byte address
- host_be  input  4  host byte lanes
- host_wdata  input  32  host write word
- host_lock  input  1  keep ownership after this grant
- host_gnt  output  1  host command issued this cycle
- host_rvalid  output  1  host read data valid
- host_rdata  output  32  host read word
- mem_en  output  1  RAM command strobe
- mem_we  output  1  RAM write enable
- mem_addr  output  AW  RAM byte address; RAM uses [AW-1:2]
- mem_be  output  4  RAM byte enables
- mem_wdata  output  32  RAM write word
- mem_rdata  input  32  RAM read word, valid one cycle after a mem_en read

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE; wait counter and lock counter 0.
- FSM states and transitions:
  - IDLE: no grant.
  - CORE: core_gnt=1.
  - HOST: host_gnt=1.
  - HLOCK: host owns the port; host_gnt=1 whenever host_req=1.
- Arbitration:
  - Requests are sampled at edge N; the grant and the mem_* command are registered and valid in cycle N+1.
  - Each grant cycle carries exactly one RAM command (mem_en=1).
  - A requester deasserts or changes its request after seeing gnt. A request still high on the grant cycle counts as a new request.
  - Fixed priority: core beats host, unless host wait counter == MAX_WAIT, in which case the host wins.
  - Back-to-back grants to the same requester are allowed; throughput is 1 access/cycle.
- Wait counter:
  - Increments each cycle host_req=1 and the host is not granted; saturates at MAX_WAIT.
  - Clears on host_gnt.
- Lock:
  - A host grant with host_lock=1 moves the FSM to HLOCK; the core is blocked (core_gnt=0) while in HLOCK.
  - Exit HLOCK when host_lock=0 is sampled, host_req=0 is sampled, or the lock counter reaches LOCK_MAX. On exit, go to CORE if core_req=1, else IDLE/HOST by the normal rules.
- Read return:
  - An rvalid register tagged with the requester pulses 1 cycle after a read grant.
  - core_rdata/host_rdata = mem_rdata, gated to 0 when the matching rvalid=0.
  - Writes never produce rvalid.
- Core write data: mem_wdata = {4{core_wdata}}; mem_be = core_be.
- Simultaneous events:
  - A read grant to one requester and an rvalid to the other in the same cycle are legal and independent.
- Reset mid-operation:
  - All state clears immediately.
  - A pending rvalid is dropped.
  - A RAM write issued in the reset cycle is not guaranteed.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration. The last-granted requester loses ties; the wait counter and forced grant are removed. HLOCK behaviour is unchanged.
- Undefined: fixed core priority with the MAX_WAIT starvation guard as described above.

Test Plan:
- Core read alone: core_req=1, addr 0x10, be 0001 at edge 0 -> core_gnt=1, mem_en=1, mem_addr=0x10 in cycle 1; RAM word 0xAABBCCDD -> core_rvalid=1, core_rdata=0xAABBCCDD in cycle 2.
- Core write byte: core_wdata=0x5A, be 0100 -> mem_wdata=0x5A5A5A5A, mem_be=0100, mem_we=1, no rvalid.
- Contention: core_req and host_req held continuously, MAX_WAIT=8 -> core granted 8 consecutive cycles, host granted on the 9th, wait counter back to 0 (RR_EN: strict alternation).
- Host lock: host_lock=1 for 3 host writes while core_req=1 -> three host grants back-to-back, core_gnt=0 throughout, core granted on the cycle after lock release.
- Lock timeout: host_lock stuck 1 with host_req high, LOCK_MAX=16 -> HLOCK exits after 16 grants and the core is granted next.
- Async reset: assert reset during a pending host read -> all outputs 0 immediately; host_rvalid never pulses; first request after release is granted with 1-cycle latency.
